// File: rtl/ahb_slavemux_code.sv
// Code-region AHB-Lite data-phase response mux with a built-in default slave
// that answers every out-of-window active transfer with a two-cycle ERROR.
module ahb_slavemux_code #(
    parameter int DW  = 32,
    parameter int ECW = 8
) (
    input  logic           HCLK,
    input  logic           HRESET,
    input  logic           HSEL_ROM,
    input  logic           HSEL_DefSlave,
    input  logic [1:0]     HTRANS,
    input  logic [DW-1:0]  HRDATA_ROM,
    input  logic           HREADYOUT_ROM,
    input  logic           HRESP_ROM,
    output logic [DW-1:0]  HRDATA,
    output logic           HREADY,
    output logic           HRESP,
    output logic [ECW-1:0] ERR_CNT
);

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_ROM  = 2'b01;
    localparam logic [1:0] SEL_DEF  = 2'b10;

    typedef enum logic [1:0] {IDLE, ERR1, ERR2} def_state_t;

    def_state_t state, state_next;
    logic [1:0] sel_q;
    logic       def_ready, def_resp;
    logic       def_accept;

    // Only an active (NONSEQ/SEQ) transfer that the ROM does not claim earns an ERROR.
    assign def_accept = HREADY && HSEL_DefSlave && !HSEL_ROM && HTRANS[1];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_q <= SEL_NONE;
        end else if (HREADY) begin
            if (HSEL_ROM)
                sel_q <= SEL_ROM;
            else if (HSEL_DefSlave)
                sel_q <= SEL_DEF;
            else
                sel_q <= SEL_NONE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        def_ready  = 1'b1;
        def_resp   = 1'b0;
        case (state)
            IDLE: begin
                if (def_accept)
                    state_next = ERR1;
            end
            ERR1: begin
                def_ready  = 1'b0;
                def_resp   = 1'b1;
                state_next = ERR2;
            end
            ERR2: begin
                def_resp   = 1'b1;
                state_next = def_accept ? ERR1 : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Every ERR1 cycle is followed by ERR2, so counting in ERR1 counts completed errors.
    always_ff @(posedge HCLK) begin
        if (HRESET)
            ERR_CNT <= '0;
        else if (state == ERR1 && ERR_CNT != '1)
            ERR_CNT <= ERR_CNT + ECW'(1);
    end

    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        case (sel_q)
            SEL_ROM: begin
                HRDATA = HRDATA_ROM;
                HREADY = HREADYOUT_ROM;
                HRESP  = HRESP_ROM;
            end
            SEL_DEF: begin
                HREADY = def_ready;
                HRESP  = def_resp;
            end
            default: ;
        endcase
    end

endmodule
